// File: rtl/pwm_multichannel_if.sv
// Configuration bus for pwm_multichannel: shadow writes, mode, commit request
// and the commit_pending status returned by the PWM block.
interface pwm_multichannel_if #(
    parameter int COUNTER_WIDTH = 8,
    parameter int ADDR_WIDTH    = 3
);
    logic                     cfg_we;
    logic [ADDR_WIDTH-1:0]    cfg_addr;
    logic [COUNTER_WIDTH-1:0] cfg_wdata;
    logic                     cfg_mode;
    logic                     cfg_commit;
    logic                     commit_pending;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cfg_mode, cfg_commit,
        input  commit_pending
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cfg_mode, cfg_commit,
        output commit_pending
    );
endinterface

// File: rtl/pwm_multichannel.sv
// Multichannel PWM sharing one edge/center-aligned counter, with shadowed
// period, duty and mode registers transferred at period boundaries.
module pwm_multichannel #(
    parameter int COUNTER_WIDTH = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDR_WIDTH    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    pwm_multichannel_if.slave        cfg,
    output logic [NUM_CHANNELS-1:0]  pwm_out,
    output logic                     period_end,
    output logic [COUNTER_WIDTH-1:0] counter
);
    localparam int CW = COUNTER_WIDTH;
    localparam int NC = NUM_CHANNELS;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    logic [CW-1:0]         cnt_q, cnt_d;
    dir_e                  dir_q, dir_d;
    logic [CW-1:0]         per_q, per_d;
    logic [CW-1:0]         sh_per_q, sh_per_d;
    logic [NC-1:0][CW-1:0] duty_q, duty_d;
    logic [NC-1:0][CW-1:0] sh_duty_q, sh_duty_d;
    logic                  mode_q, mode_d;
    logic                  sh_mode_q, sh_mode_d;
    logic                  pend_q, pend_d;
    logic [NC-1:0]         pwm_q, pwm_d;
    logic                  pe_q, pe_d;
    logic                  boundary;
    logic                  new_commit;
    logic [CW-1:0]         last;

    assign new_commit = cfg.cfg_commit && !pend_q;
    assign last       = per_q - CW'(1);

    always_comb begin
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        per_d     = per_q;
        duty_d    = duty_q;
        mode_d    = mode_q;
        sh_per_d  = sh_per_q;
        sh_duty_d = sh_duty_q;
        sh_mode_d = sh_mode_q;
        pend_d    = pend_q | cfg.cfg_commit;
        pwm_d     = pwm_q;
        pe_d      = 1'b0;
        boundary  = 1'b0;

        if (cfg.cfg_we) begin
            if (cfg.cfg_addr == '0) sh_per_d = cfg.cfg_wdata;
            for (int k = 0; k < NC; k++) begin
                if (cfg.cfg_addr == ADDR_WIDTH'(k + 1)) sh_duty_d[k] = cfg.cfg_wdata;
            end
        end
        if (new_commit) sh_mode_d = cfg.cfg_mode;

        if (enable) begin
            for (int i = 0; i < NC; i++) begin
                pwm_d[i] = (per_q != '0) && (cnt_q < duty_q[i]);
            end
            if (per_q == '0) begin
                boundary = 1'b1;
                cnt_d    = '0;
                dir_d    = DIR_UP;
            end else if (!mode_q) begin
                if (cnt_q == last) begin
                    boundary = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (dir_q == DIR_UP) begin
                // the top value is held one extra cycle as the direction turns
                if (cnt_q == last) dir_d = DIR_DOWN;
                else               cnt_d = cnt_q + CW'(1);
            end else begin
                if (cnt_q == '0) begin
                    boundary = 1'b1;
                    dir_d    = DIR_UP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            pe_d = boundary;
            if (boundary && pend_d) begin
                per_d  = sh_per_q;
                duty_d = sh_duty_q;
                mode_d = new_commit ? cfg.cfg_mode : sh_mode_q;
                pend_d = 1'b0;
                cnt_d  = '0;
                dir_d  = DIR_UP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            per_q     <= '0;
            sh_per_q  <= '0;
            duty_q    <= '0;
            sh_duty_q <= '0;
            mode_q    <= 1'b0;
            sh_mode_q <= 1'b0;
            pend_q    <= 1'b0;
            pwm_q     <= '0;
            pe_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            per_q     <= per_d;
            sh_per_q  <= sh_per_d;
            duty_q    <= duty_d;
            sh_duty_q <= sh_duty_d;
            mode_q    <= mode_d;
            sh_mode_q <= sh_mode_d;
            pend_q    <= pend_d;
            pwm_q     <= pwm_d;
            pe_q      <= pe_d;
        end
    end

    assign counter            = cnt_q;
    assign pwm_out            = pwm_q;
    assign period_end         = pe_q;
    assign cfg.commit_pending = pend_q;
endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed self-checking bench for pwm_multichannel: edge mode, shadow/commit
// timing, duty extremes, P=0, center mode, enable freeze and async reset.
module tb_pwm_multichannel;
    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] pwm_out;
    logic       period_end;
    logic [7:0] counter;

    int n_cmp;
    int n_err;

    pwm_multichannel_if #(.COUNTER_WIDTH(8), .ADDR_WIDTH(3)) cfg_bus ();

    pwm_multichannel #(
        .COUNTER_WIDTH(8),
        .NUM_CHANNELS (4),
        .ADDR_WIDTH   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg       (cfg_bus),
        .pwm_out   (pwm_out),
        .period_end(period_end),
        .counter   (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_wdata = d;
        step();
        cfg_bus.cfg_we = 1'b0;
    endtask

    // center-aligned count for P=8 at index i after a restart
    function automatic int cc(input int i);
        int m;
        m = i % 16;
        return (m < 8) ? m : 15 - m;
    endfunction

    task automatic check_all(input string tag, input int c, input int p,
                             input int pe, input int pd);
        check($sformatf("%s cnt", tag), 32'(counter), 32'(c));
        check($sformatf("%s pwm", tag), 32'(pwm_out), 32'(p));
        check($sformatf("%s pe", tag), 32'(period_end), 32'(pe));
        check($sformatf("%s pend", tag), 32'(cfg_bus.commit_pending), 32'(pd));
    endtask

    initial begin
        int ec, ep, epe, epd, d0, i, p0;
        bit frozen;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        enable = 1'b0;
        cfg_bus.cfg_we = 1'b0;
        cfg_bus.cfg_addr = '0;
        cfg_bus.cfg_wdata = '0;
        cfg_bus.cfg_mode = 1'b0;
        cfg_bus.cfg_commit = 1'b0;
        repeat (3) step();
        check_all("rst", 0, 0, 0, 0);
        reset = 1'b1;

        wr(3'd0, 8'd10);
        wr(3'd1, 8'd5);
        wr(3'd2, 8'd0);
        wr(3'd3, 8'd12);
        cfg_bus.cfg_commit = 1'b1;
        step();
        cfg_bus.cfg_commit = 1'b0;
        check_all("precommit", 0, 0, 0, 1);
        enable = 1'b1;

        // edge mode, duty change, same-cycle write+commit, then P=0
        for (int k = 1; k <= 82; k++) begin
            step();
            if (k <= 71) begin
                ec  = (k - 1) % 10;
                epe = (ec == 0);
                d0  = (k >= 42) ? 3 : 5;
                p0  = (k >= 2) && (((k - 2) % 10) < d0);
                ep  = {(k >= 2), 1'b0} * 2 + p0;
            end else begin
                ec = 0; epe = 1; ep = 0;
            end
            epd = ((k >= 36 && k <= 40) || (k >= 62 && k <= 70)) ? 1 : 0;
            check_all($sformatf("edge k%0d", k), ec, ep, epe, epd);
            cfg_bus.cfg_we = 1'b0;
            cfg_bus.cfg_commit = 1'b0;
            if (k == 30) begin
                cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 3'd1; cfg_bus.cfg_wdata = 8'd3;
            end
            if (k == 35 || k == 61) cfg_bus.cfg_commit = 1'b1;
            if (k == 60) begin
                cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 3'd0; cfg_bus.cfg_wdata = 8'd0;
                cfg_bus.cfg_commit = 1'b1;
            end
            if (k == 80) begin
                cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 3'd0; cfg_bus.cfg_wdata = 8'd8;
            end
            if (k == 81) begin
                cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 3'd1; cfg_bus.cfg_wdata = 8'd3;
            end
            if (k == 82) begin
                cfg_bus.cfg_commit = 1'b1; cfg_bus.cfg_mode = 1'b1;
            end
        end

        // center mode P=8 duty0=3, freeze j=37..43 with write+commit inside
        for (int j = 0; j <= 61; j++) begin
            step();
            frozen = (j >= 37 && j <= 43);
            if (j <= 36)    i = j;
            else if (frozen) i = 36;
            else            i = j - 7;
            ec  = cc(i);
            epe = frozen ? 0 : ((i % 16) == 0);
            p0  = (i == 0) ? 0 : (cc(i - 1) < ((i >= 49) ? 1 : 3));
            ep  = (i >= 1) ? (4 + p0) : 0;
            epd = (j >= 38 && i <= 47) ? 1 : 0;
            check_all($sformatf("ctr j%0d", j), ec, ep, epe, epd);
            cfg_bus.cfg_we = 1'b0;
            cfg_bus.cfg_commit = 1'b0;
            if (j == 36) enable = 1'b0;
            if (j == 37) begin
                cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 3'd1; cfg_bus.cfg_wdata = 8'd1;
                cfg_bus.cfg_commit = 1'b1;
            end
            if (j == 43) enable = 1'b1;
        end

        // counter is 6 here; reset lands between clock edges
        check("pre-rst cnt", 32'(counter), 32'd6);
        #3;
        reset = 1'b0;
        #1;
        check_all("async rst", 0, 0, 0, 0);
        step();
        step();
        check_all("held rst", 0, 0, 0, 0);
        reset = 1'b1;
        step();
        check_all("post rst", 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
